// File: rtl/ssd1331_spi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ssd1331_spi_tx_scheduler
// Description : Sequences the MOSI SPI buffer/serializer for an SSD1331 OLED.
//               Drives the panel power-on reset, round-robin arbitrates an
//               init/config channel (ch0) and a draw channel (ch1), latches
//               the granted burst, starts the buffer, waits for completion
//               under a watchdog and enforces an inter-burst CS gap.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd1331_spi_tx_scheduler #(
  parameter int WIDTH    = 8,
  parameter int N        = 8,
  parameter int RST_CYC  = 16,
  parameter int RST_WAIT = 64,
  parameter int GAP_CYC  = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic               i_SCK,
  input  logic               i_RST,
  input  logic               i_REQ0,
  input  logic [WIDTH*N-1:0] i_DATA0,
  input  logic [N-1:0]       i_DC0,
  input  logic [4:0]         i_NTX0,
  input  logic               i_REQ1,
  input  logic [WIDTH*N-1:0] i_DATA1,
  input  logic [N-1:0]       i_DC1,
  input  logic [4:0]         i_NTX1,
  output logic               o_GNT0,
  output logic               o_GNT1,
  output logic               o_DONE0,
  output logic               o_DONE1,
  output logic               o_ERR,
  output logic               o_BUSY,
  output logic               o_RESN,
  output logic [WIDTH*N-1:0] o_DATA,
  output logic [N-1:0]       o_DC,
  output logic [4:0]         o_N_transmit,
  output logic               o_START,
  input  logic               i_FINAL_BYTE,
  input  logic               i_FINAL_BIT
);

  // One shared counter covers reset timing, watchdog and gap; size it for
  // the largest of those intervals.
  localparam int M1      = (RST_CYC > RST_WAIT) ? RST_CYC : RST_WAIT;
  localparam int M2      = (GAP_CYC > TIMEOUT) ? GAP_CYC : TIMEOUT;
  localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_PWR_RST  = 3'd0,
    S_PWR_WAIT = 3'd1,
    S_IDLE     = 3'd2,
    S_LAUNCH   = 3'd3,
    S_WAIT     = 3'd4,
    S_GAP      = 3'd5,
    S_ZDONE    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rr_q, rr_d;      // last granted channel
  logic                 ch_q, ch_d;      // channel owning the current burst
  logic                 resn_q, resn_d;
  logic [WIDTH*N-1:0]   data_q, data_d;
  logic [N-1:0]         dc_q, dc_d;
  logic [4:0]           ntx_q, ntx_d;
  logic                 start_q, start_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic                 err_q, err_d;

  logic                 sel0, sel1;
  logic [4:0]           ntx_raw;

  // Arbitration: on contention, grant the channel not served last time.
  always_comb begin
    sel0    = i_REQ0 & (~i_REQ1 | rr_q);
    sel1    = i_REQ1 & (~i_REQ0 | ~rr_q);
    ntx_raw = sel1 ? i_NTX1 : i_NTX0;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    resn_d  = resn_q;
    data_d  = data_q;
    dc_d    = dc_q;
    ntx_d   = ntx_q;
    start_d = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_PWR_RST: begin
        resn_d = 1'b0;
        if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          cnt_d   = '0;
          resn_d  = 1'b1;
          state_d = S_PWR_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PWR_WAIT: begin
        if (cnt_q == CNT_W'(RST_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_IDLE: begin
        if (sel0 || sel1) begin
          ch_d   = sel1;
          rr_d   = sel1;
          gnt0_d = sel0;
          gnt1_d = sel1;
          data_d = sel1 ? i_DATA1 : i_DATA0;
          dc_d   = sel1 ? i_DC1 : i_DC0;
          ntx_d  = (ntx_raw > 5'(N)) ? 5'(N) : ntx_raw;
          // An empty burst never touches the buffer.
          state_d = (ntx_raw == 5'd0) ? S_ZDONE : S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (i_FINAL_BYTE && i_FINAL_BIT) begin
          done0_d = ~ch_q;
          done1_d = ch_q;
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done0_d = ~ch_q;
          done1_d = ch_q;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ZDONE: begin
        done0_d = ~ch_q;
        done1_d = ch_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_PWR_RST;
        cnt_d   = '0;
        resn_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_SCK) begin
    if (i_RST) begin
      state_q <= S_PWR_RST;
      cnt_q   <= '0;
      rr_q    <= 1'b1;
      ch_q    <= 1'b0;
      resn_q  <= 1'b0;
      data_q  <= '0;
      dc_q    <= '0;
      ntx_q   <= '0;
      start_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      resn_q  <= resn_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      ntx_q   <= ntx_d;
      start_q <= start_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
    end
  end

  // Busy spans the whole burst, from the grant cycle to the end of the gap.
  always_comb begin
    o_BUSY = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
             (state_q == S_GAP)    || (state_q == S_ZDONE);
  end

  assign o_GNT0       = gnt0_q;
  assign o_GNT1       = gnt1_q;
  assign o_DONE0      = done0_q;
  assign o_DONE1      = done1_q;
  assign o_ERR        = err_q;
  assign o_RESN       = resn_q;
  assign o_DATA       = data_q;
  assign o_DC         = dc_q;
  assign o_N_transmit = ntx_q;
  assign o_START      = start_q;

endmodule
`default_nettype wire

// File: doc/ssd1331_spi_tx_scheduler.md
Name: ssd1331_spi_tx_scheduler

Overview:
- Controller that sits in front of the N-byte MOSI SPI buffer/serializer pair and sequences it for the SSD1331 OLED.
- Runs the panel power-on reset pulse on o_RESN, then round-robin arbitrates two requesters (ch0 = init/config, ch1 = draw engine) for the SPI datapath.
- Latches the granted burst, issues a one-cycle start to the buffer and detects completion.
- Enforces an inter-burst CS gap and a watchdog timeout.

Parameters:
WIDTH, 8, bits per SPI byte
N, 8, max bytes per burst; bundle width is WIDTH*N
RST_CYC, 16, SCK cycles o_RESN is held low after reset
RST_WAIT, 64, SCK cycles after o_RESN release before the first grant
GAP_CYC, 4, idle SCK cycles between bursts
TIMEOUT, 4096, SCK cycles allowed per burst before abort

Ports:
i_SCK  in  1  clock; all logic posedge i_SCK
i_RST  in  1  synchronous, active-high reset
i_REQ0  in  1  ch0 request; level, held until o_DONE0
i_DATA0  in  WIDTH*N  ch0 byte bundle; byte0 in LSBs
i_DC0  in  N  ch0 D/C bit per byte
i_NTX0  in  5  ch0 byte count
i_REQ1, i_DATA1, i_DC1, i_NTX1  in  1/WIDTH*N/N/5  ch1, same as ch0
o_GNT0, o_GNT1  out  1  one-cycle pulse when that channel's burst is latched
o_DONE0, o_DONE1  out  1  one-cycle pulse when the granted burst completes or is aborted
o_ERR  out  1  one-cycle pulse on watchdog abort, coincident with o_DONEx
o_BUSY  out  1  high from grant until gap end
o_RESN  out  1  panel reset, active low
o_DATA  out  WIDTH*N  latched bundle to the buffer
o_DC  out  N  latched D/C to the buffer
o_N_transmit  out  5  latched, clamped count to the buffer
o_START  out  1  one-cycle start to the buffer
i_FINAL_BYTE  in  1  buffer's final-byte flag
i_FINAL_BIT  in  1  serializer's final-bit flag

Behaviour:
- Reset (i_RST=1 at an edge) values: state PWR_RST, o_RESN=0, counters 0, rr pointer=1 (ch0 wins first), o_DATA/o_DC/o_N_transmit=0.
- Reset values, continued: o_START/o_GNTx/o_DONEx/o_ERR=0, o_BUSY=0.
- Reset mid-burst abandons the burst with no o_DONEx; the buffer shares i_RST.
- States:
  - PWR_RST: o_RESN=0 for RST_CYC cycles, then goes to PWR_WAIT.
  - PWR_WAIT: o_RESN=1; waits RST_WAIT cycles, then goes to IDLE. Requests are ignored and there are no grants before IDLE.
  - IDLE: arbitrate (see the arbitration bullet). The winner's i_DATAx/i_DCx/count are latched into o_* registers, o_GNTx pulses and the state goes to LAUNCH.
  - LAUNCH: o_START=1 for exactly this one cycle; watchdog cleared; state goes to WAIT.
  - WAIT: completes when i_FINAL_BYTE=1 and i_FINAL_BIT=1 at the same edge. That edge pulses o_DONEx next cycle and goes to GAP. If the watchdog reaches TIMEOUT first, o_DONEx and o_ERR pulse together and the state goes to GAP.
  - GAP: GAP_CYC cycles, then goes to IDLE; o_BUSY drops on entry to IDLE.
- Arbitration:
  - Both requests high: grant the channel opposite to the rr pointer. The pointer updates to the granted channel.
  - Only one request high: grant it.
- Count rules:
  - NTX > N is clamped to N.
  - NTX = 0: o_GNTx then o_DONEx on the next cycle. No o_START and no GAP; returns to IDLE.
- o_DATA/o_DC/o_N_transmit stay stable from grant until the next grant; requester inputs may change after o_GNTx.
- A request still high in the IDLE cycle after its own o_DONEx is treated as a new request.
- Minimum grant-to-grant spacing is LAUNCH + WAIT + GAP_CYC.
- o_BUSY=1 in LAUNCH, WAIT and GAP.

Test Plan:
- Power-on: release i_RST → o_RESN low for exactly 16 cycles, high afterward. i_REQ0=1 held from reset gives o_GNT0 no earlier than cycle 16+64.
- Single burst: i_REQ0, NTX0=3, DATA0=0x0000_0000_00A0_15AF, DC0=0 → o_GNT0, o_START one cycle later, o_N_transmit=3. FINAL_BYTE&FINAL_BIT at the same edge → o_DONE0 next cycle; next grant ≥4 cycles later.
- Round robin: REQ0 and REQ1 both held for 4 bursts → grants in order ch0,ch1,ch0,ch1; a lone REQ1 gets back-to-back grants.
- Clamp/zero: NTX1=12 → o_N_transmit=8. NTX0=0 → o_GNT0 then o_DONE0 on the next cycle, with o_START never asserted.
- Watchdog: no final flags after o_START → o_DONEx and o_ERR pulse at cycle 4096 after LAUNCH, then the next request is served.
- Reset mid-WAIT: assert i_RST → next cycle is in PWR_RST, o_RESN=0, o_BUSY=0, no o_DONEx.
